// File: rtl/decode_queue.sv
// decode_queue: RV32I instruction queue feeding a registered decode stage.
//
// Fetch pushes {instruction, pc} pairs into a circular FIFO of DEPTH entries.
// The head entry is decoded combinationally. When the output register is free
// or being consumed, it loads the decoded head and the entry pops, so a word
// enqueued at one edge can appear on dec_* after the following edge.
// Total buffering is DEPTH queue entries plus the output register.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rdy              global enable; low freezes all state and drops if_ready
//   flush            synchronous clear of queue and output register
//   if_valid/if_ready/if_ins/if_pc      fetch-side handshake and payload
//   dec_valid/dec_ready                 decode-side handshake
//   dec_opcode/ophead/imm/rs1/rs2/rd/pc/illegal   decoded instruction fields
//   count            queue occupancy, output register excluded
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int OPW   = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       if_valid,
  input  logic [31:0]                if_ins,
  input  logic [31:0]                if_pc,
  output logic                       if_ready,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [OPW-1:0]             dec_opcode,
  output logic [6:0]                 dec_ophead,
  output logic [31:0]                dec_imm,
  output logic [4:0]                 dec_rs1,
  output logic [4:0]                 dec_rs2,
  output logic [4:0]                 dec_rd,
  output logic [31:0]                dec_pc,
  output logic                       dec_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Opcode codes; 0 is reserved for unrecognised instructions.
  localparam int OP_LUI   = 1;
  localparam int OP_AUIPC = 2;
  localparam int OP_JAL   = 3;
  localparam int OP_JALR  = 4;
  localparam int OP_BEQ   = 5;
  localparam int OP_BNE   = 6;
  localparam int OP_BLT   = 7;
  localparam int OP_BGE   = 8;
  localparam int OP_BLTU  = 9;
  localparam int OP_BGEU  = 10;
  localparam int OP_LB    = 11;
  localparam int OP_LH    = 12;
  localparam int OP_LW    = 13;
  localparam int OP_LBU   = 14;
  localparam int OP_LHU   = 15;
  localparam int OP_SB    = 16;
  localparam int OP_SH    = 17;
  localparam int OP_SW    = 18;
  localparam int OP_ADDI  = 19;
  localparam int OP_SLTI  = 20;
  localparam int OP_SLTIU = 21;
  localparam int OP_XORI  = 22;
  localparam int OP_ORI   = 23;
  localparam int OP_ANDI  = 24;
  localparam int OP_SLLI  = 25;
  localparam int OP_SRLI  = 26;
  localparam int OP_SRAI  = 27;
  localparam int OP_ADD   = 28;
  localparam int OP_SUB   = 29;
  localparam int OP_SLL   = 30;
  localparam int OP_SLT   = 31;
  localparam int OP_SLTU  = 32;
  localparam int OP_XOR   = 33;
  localparam int OP_SRL   = 34;
  localparam int OP_SRA   = 35;
  localparam int OP_OR    = 36;
  localparam int OP_AND   = 37;

  // Queue storage (not reset; validity is tracked by the pointers/count)
  logic [31:0]    ins_mem [DEPTH];
  logic [31:0]    pc_mem  [DEPTH];

  logic [AW-1:0]  head_reg;
  logic [AW-1:0]  tail_reg;
  logic [CW-1:0]  count_reg;

  logic           dec_valid_reg;
  logic [OPW-1:0] dec_opcode_reg;
  logic [6:0]     dec_ophead_reg;
  logic [31:0]    dec_imm_reg;
  logic [4:0]     dec_rs1_reg;
  logic [4:0]     dec_rs2_reg;
  logic [4:0]     dec_rd_reg;
  logic [31:0]    dec_pc_reg;
  logic           dec_illegal_reg;

  logic           push;
  logic           pop;

  // Acceptance depends only on current occupancy: a full queue never takes a
  // word, even in a cycle where the head pops.
  assign if_ready = rdy && (count_reg < CW'(DEPTH));
  assign push     = if_valid && if_ready && !flush;
  assign pop      = rdy && !flush && (count_reg != '0) && (!dec_valid_reg || dec_ready);

  // Combinational decode of the head entry
  logic [31:0] head_ins;
  logic [31:0] head_pc;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  int          code;
  logic [31:0] imm_sel;
  logic        legal;

  assign head_ins = ins_mem[head_reg];
  assign head_pc  = pc_mem[head_reg];
  assign op       = head_ins[6:0];
  assign f3       = head_ins[14:12];
  assign f7       = head_ins[31:25];

  assign imm_i  = {{20{head_ins[31]}}, head_ins[31:20]};
  assign imm_s  = {{20{head_ins[31]}}, head_ins[31:25], head_ins[11:7]};
  assign imm_b  = {{19{head_ins[31]}}, head_ins[31], head_ins[7], head_ins[30:25], head_ins[11:8], 1'b0};
  assign imm_u  = {head_ins[31:12], 12'b0};
  assign imm_j  = {{11{head_ins[31]}}, head_ins[31], head_ins[19:12], head_ins[20], head_ins[30:21], 1'b0};
  assign imm_sh = {27'b0, head_ins[24:20]};

  always_comb begin
    code    = 0;
    imm_sel = '0;
    legal   = 1'b1;
    case (op)
      7'b0110111: begin code = OP_LUI;   imm_sel = imm_u; end
      7'b0010111: begin code = OP_AUIPC; imm_sel = imm_u; end
      7'b1101111: begin code = OP_JAL;   imm_sel = imm_j; end
      7'b1100111: begin
        code    = OP_JALR;
        imm_sel = imm_i;
        legal   = (f3 == 3'b000);
      end
      7'b1100011: begin
        imm_sel = imm_b;
        case (f3)
          3'b000:  code = OP_BEQ;
          3'b001:  code = OP_BNE;
          3'b100:  code = OP_BLT;
          3'b101:  code = OP_BGE;
          3'b110:  code = OP_BLTU;
          3'b111:  code = OP_BGEU;
          default: legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        imm_sel = imm_i;
        case (f3)
          3'b000:  code = OP_LB;
          3'b001:  code = OP_LH;
          3'b010:  code = OP_LW;
          3'b100:  code = OP_LBU;
          3'b101:  code = OP_LHU;
          default: legal = 1'b0;
        endcase
      end
      7'b0100011: begin
        imm_sel = imm_s;
        case (f3)
          3'b000:  code = OP_SB;
          3'b001:  code = OP_SH;
          3'b010:  code = OP_SW;
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        imm_sel = imm_i;
        case (f3)
          3'b000: code = OP_ADDI;
          3'b010: code = OP_SLTI;
          3'b011: code = OP_SLTIU;
          3'b100: code = OP_XORI;
          3'b110: code = OP_ORI;
          3'b111: code = OP_ANDI;
          3'b001: begin
            code    = OP_SLLI;
            imm_sel = imm_sh;
            legal   = (f7 == 7'h00);
          end
          default: begin  // 3'b101: shift-right, funct7 picks logical/arith
            imm_sel = imm_sh;
            if (f7 == 7'h00)      code  = OP_SRLI;
            else if (f7 == 7'h20) code  = OP_SRAI;
            else                  legal = 1'b0;
          end
        endcase
      end
      7'b0110011: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'b000:  code = OP_ADD;
            3'b001:  code = OP_SLL;
            3'b010:  code = OP_SLT;
            3'b011:  code = OP_SLTU;
            3'b100:  code = OP_XOR;
            3'b101:  code = OP_SRL;
            3'b110:  code = OP_OR;
            default: code = OP_AND;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'b000) begin
          code = OP_SUB;
        end else if (f7 == 7'h20 && f3 == 3'b101) begin
          code = OP_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    // Unrecognised words travel down the pipe with zeroed opcode/immediate
    if (!legal) begin
      code    = 0;
      imm_sel = '0;
    end
  end

  // Queue storage write
  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem[tail_reg] <= if_ins;
      pc_mem[tail_reg]  <= if_pc;
    end
  end

  // Pointers, occupancy and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      dec_valid_reg   <= 1'b0;
      dec_opcode_reg  <= '0;
      dec_ophead_reg  <= '0;
      dec_imm_reg     <= '0;
      dec_rs1_reg     <= '0;
      dec_rs2_reg     <= '0;
      dec_rd_reg      <= '0;
      dec_pc_reg      <= '0;
      dec_illegal_reg <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        head_reg      <= '0;
        tail_reg      <= '0;
        count_reg     <= '0;
        dec_valid_reg <= 1'b0;
      end else begin
        if (push) begin
          tail_reg <= tail_reg + AW'(1);
        end
        if (pop) begin
          head_reg        <= head_reg + AW'(1);
          dec_valid_reg   <= 1'b1;
          dec_opcode_reg  <= OPW'(code);
          dec_ophead_reg  <= head_ins[6:0];
          dec_imm_reg     <= imm_sel;
          dec_rs1_reg     <= head_ins[19:15];
          dec_rs2_reg     <= head_ins[24:20];
          dec_rd_reg      <= head_ins[11:7];
          dec_pc_reg      <= head_pc;
          dec_illegal_reg <= !legal;
        end else if (dec_ready) begin
          dec_valid_reg <= 1'b0;
        end
        if (push && !pop) begin
          count_reg <= count_reg + CW'(1);
        end else if (pop && !push) begin
          count_reg <= count_reg - CW'(1);
        end
      end
    end
  end

  assign dec_valid   = dec_valid_reg;
  assign dec_opcode  = dec_opcode_reg;
  assign dec_ophead  = dec_ophead_reg;
  assign dec_imm     = dec_imm_reg;
  assign dec_rs1     = dec_rs1_reg;
  assign dec_rs2     = dec_rs2_reg;
  assign dec_rd      = dec_rd_reg;
  assign dec_pc      = dec_pc_reg;
  assign dec_illegal = dec_illegal_reg;
  assign count       = count_reg;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed self-checking bench for decode_queue (DEPTH=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_decode_queue;

  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd19;
  localparam logic [5:0] OP_SRAI = 6'd27;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_ins = '0;
  logic [31:0] if_pc = '0;
  logic        if_ready;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [5:0]  dec_opcode;
  logic [6:0]  dec_ophead;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_pc;
  logic        dec_illegal;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  decode_queue #(.DEPTH(4), .OPW(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_valid(if_valid), .if_ins(if_ins), .if_pc(if_pc), .if_ready(if_ready),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode), .dec_ophead(dec_ophead), .dec_imm(dec_imm),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_pc(dec_pc),
    .dec_illegal(dec_illegal), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // addi x<rd>, x0, <imm>
  function automatic logic [31:0] mk_addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; if_valid = 1'b0; dec_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got %0b want 0", dec_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if ({dec_opcode, dec_imm, dec_pc, dec_rd, dec_illegal} !== '0) begin errors++;
      $display("FAIL reset_fields got op=%0d imm=%h pc=%h rd=%0d ill=%0b want all 0", dec_opcode, dec_imm, dec_pc, dec_rd, dec_illegal); end
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %0b want 1", if_ready); end
    // Reset mid-operation: one word held, one queued
    if_valid = 1'b1; if_ins = mk_addi(5'd7, 12'd7); if_pc = 32'h50;
    tick(); tick();
    if_valid = 1'b0;
    checks++; if (dec_valid !== 1'b1 || count !== 3'd1) begin errors++;
      $display("FAIL pre_midreset got valid=%0b count=%0d want 1/1", dec_valid, count); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (dec_valid !== 1'b0 || count !== 3'd0 || if_ready !== 1'b1) begin errors++;
      $display("FAIL midreset got valid=%0b count=%0d if_ready=%0b want 0/0/1", dec_valid, count, if_ready); end
    tick();
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_ghost got valid=%0b want 0", dec_valid); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    dec_ready = 1'b1;
    if_valid = 1'b1; if_ins = 32'hFFF00093; if_pc = 32'h0;
    tick();  // edge N: enqueue
    checks++; if (dec_valid !== 1'b0 || count !== 3'd1) begin errors++;
      $display("FAIL stream_edgeN got valid=%0b count=%0d want 0/1", dec_valid, count); end
    if_ins = mk_addi(5'd2, 12'd2); if_pc = 32'h4;
    tick();  // edge N+1: first word on outputs, second enqueued
    if_valid = 1'b0;
    checks++; if (dec_valid !== 1'b1 || dec_opcode !== OP_ADDI || dec_rd !== 5'd1 || dec_rs1 !== 5'd0 ||
                  dec_imm !== 32'hFFFFFFFF || dec_pc !== 32'h0 || dec_ophead !== 7'h13) begin errors++;
      $display("FAIL stream_addi got v=%0b op=%0d rd=%0d rs1=%0d imm=%h pc=%h want 1/19/1/0/ffffffff/0",
               dec_valid, dec_opcode, dec_rd, dec_rs1, dec_imm, dec_pc); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count got %0d want 1", count); end
    tick();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h4 || dec_rd !== 5'd2 || dec_imm !== 32'd2) begin errors++;
      $display("FAIL stream_second got v=%0b pc=%h rd=%0d imm=%h want 1/4/2/2", dec_valid, dec_pc, dec_rd, dec_imm); end
    tick();
    checks++; if (dec_valid !== 1'b0 || count !== 3'd0) begin errors++;
      $display("FAIL stream_drain got v=%0b count=%0d want 0/0", dec_valid, count); end
    $display("test_stream done");
  endtask

  task automatic test_backpressure();
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if_valid = 1'b1; if_ins = mk_addi(5'(i + 1), 12'(i)); if_pc = 32'h100 + 32'(4 * i);
      tick();
    end
    checks++; if (count !== 3'd4 || if_ready !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 32'h100) begin errors++;
      $display("FAIL bp_full got count=%0d if_ready=%0b v=%0b pc=%h want 4/0/1/100", count, if_ready, dec_valid, dec_pc); end
    if_ins = mk_addi(5'd30, 12'd30); if_pc = 32'h1F0;  // sixth word, must be rejected
    tick();
    if_valid = 1'b0;
    checks++; if (count !== 3'd4 || dec_pc !== 32'h100) begin errors++;
      $display("FAIL bp_reject got count=%0d pc=%h want 4/100", count, dec_pc); end
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100 + 32'(4 * i) || dec_rd !== 5'(i + 1)) begin errors++;
        $display("FAIL bp_order%0d got v=%0b pc=%h rd=%0d want 1/%h/%0d", i, dec_valid, dec_pc, dec_rd,
                 32'h100 + 32'(4 * i), i + 1); end
      $display("bp txn pc=%h rd=%0d", dec_pc, dec_rd);
      tick();
    end
    checks++; if (dec_valid !== 1'b0 || count !== 3'd0) begin errors++;
      $display("FAIL bp_empty got v=%0b count=%0d want 0/0", dec_valid, count); end
    $display("test_backpressure done");
  endtask

  task automatic test_decode();
    dec_ready = 1'b1;
    if_valid = 1'b1; if_ins = 32'hFE208CE3; if_pc = 32'h300; tick();
    if_ins = 32'h001000EF; if_pc = 32'h304; tick();
    checks++; if (dec_opcode !== OP_BEQ || dec_imm !== 32'hFFFFFFF8 || dec_rs1 !== 5'd1 || dec_rs2 !== 5'd2 ||
                  dec_illegal !== 1'b0) begin errors++;
      $display("FAIL dec_beq got op=%0d imm=%h rs1=%0d rs2=%0d ill=%0b want 5/fffffff8/1/2/0",
               dec_opcode, dec_imm, dec_rs1, dec_rs2, dec_illegal); end
    if_ins = 32'h4041D193; if_pc = 32'h308; tick();
    if_valid = 1'b0;
    checks++; if (dec_opcode !== OP_JAL || dec_imm !== 32'h00000800 || dec_rd !== 5'd1 || dec_pc !== 32'h304) begin errors++;
      $display("FAIL dec_jal got op=%0d imm=%h rd=%0d pc=%h want 3/800/1/304", dec_opcode, dec_imm, dec_rd, dec_pc); end
    tick();
    checks++; if (dec_opcode !== OP_SRAI || dec_imm !== 32'd4 || dec_rd !== 5'd3 || dec_rs1 !== 5'd3) begin errors++;
      $display("FAIL dec_srai got op=%0d imm=%h rd=%0d rs1=%0d want 27/4/3/3", dec_opcode, dec_imm, dec_rd, dec_rs1); end
    tick();
    $display("test_decode done");
  endtask

  task automatic test_flush();
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if_valid = 1'b1; if_ins = mk_addi(5'(i + 10), 12'(i)); if_pc = 32'h400 + 32'(4 * i);
      tick();
    end
    checks++; if (count !== 3'd3 || dec_valid !== 1'b1) begin errors++;
      $display("FAIL flush_setup got count=%0d v=%0b want 3/1", count, dec_valid); end
    flush = 1'b1; if_ins = mk_addi(5'd20, 12'd99); if_pc = 32'h999;
    tick();
    flush = 1'b0; if_valid = 1'b0; dec_ready = 1'b1;
    checks++; if (count !== 3'd0 || dec_valid !== 1'b0) begin errors++;
      $display("FAIL flush_clear got count=%0d v=%0b want 0/0", count, dec_valid); end
    tick();
    checks++; if (dec_valid !== 1'b0 || count !== 3'd0 || if_ready !== 1'b1) begin errors++;
      $display("FAIL flush_word_absent got v=%0b count=%0d pc=%h want 0/0", dec_valid, count, dec_pc); end
    $display("test_flush done");
  endtask

  task automatic test_illegal_freeze();
    dec_ready = 1'b1;
    if_valid = 1'b1; if_ins = 32'hFFFFFFFF; if_pc = 32'h200; tick();
    if_ins = mk_addi(5'd3, 12'd3); if_pc = 32'h204; tick();
    checks++; if (dec_valid !== 1'b1 || dec_illegal !== 1'b1 || dec_opcode !== 6'd0 || dec_imm !== 32'd0 ||
                  dec_ophead !== 7'h7F || dec_pc !== 32'h200) begin errors++;
      $display("FAIL illegal got v=%0b ill=%0b op=%0d imm=%h oph=%h pc=%h want 1/1/0/0/7f/200",
               dec_valid, dec_illegal, dec_opcode, dec_imm, dec_ophead, dec_pc); end
    rdy = 1'b0; if_ins = mk_addi(5'd4, 12'd4); if_pc = 32'h208;
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL freeze_if_ready got %0b want 0", if_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200 || count !== 3'd1 || dec_illegal !== 1'b1) begin errors++;
        $display("FAIL freeze%0d got v=%0b pc=%h count=%0d ill=%0b want 1/200/1/1", i, dec_valid, dec_pc, count, dec_illegal); end
    end
    rdy = 1'b1;
    tick();
    if_valid = 1'b0;
    checks++; if (dec_pc !== 32'h204 || dec_rd !== 5'd3 || dec_imm !== 32'd3 || dec_illegal !== 1'b0) begin errors++;
      $display("FAIL resume1 got pc=%h rd=%0d imm=%h ill=%0b want 204/3/3/0", dec_pc, dec_rd, dec_imm, dec_illegal); end
    tick();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h208 || dec_rd !== 5'd4) begin errors++;
      $display("FAIL resume2 got v=%0b pc=%h rd=%0d want 1/208/4", dec_valid, dec_pc, dec_rd); end
    tick();
    checks++; if (dec_valid !== 1'b0 || count !== 3'd0) begin errors++;
      $display("FAIL resume_drain got v=%0b count=%0d want 0/0", dec_valid, count); end
    $display("test_illegal_freeze done");
  endtask

  task automatic test_wrap();
    logic [31:0] exp_q[$];
    int sent = 0;
    int got = 0;
    bit acc;
    for (int cyc = 0; cyc < 400 && got < 13; cyc++) begin
      dec_ready = 1'($urandom_range(0, 1));
      if_valid  = (sent < 13);
      if_ins    = mk_addi(5'd5, 12'(sent));
      if_pc     = 32'h1000 + 32'(4 * sent);
      #1;
      acc = if_valid && if_ready;
      if (dec_valid && dec_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL wrap_extra got pc=%h want nothing", dec_pc);
        end else begin
          if (dec_pc !== exp_q[0] || dec_imm !== ((exp_q[0] - 32'h1000) >> 2)) begin errors++;
            $display("FAIL wrap_order got pc=%h imm=%h want pc=%h imm=%h", dec_pc, dec_imm,
                     exp_q[0], (exp_q[0] - 32'h1000) >> 2); end
          void'(exp_q.pop_front());
        end
        $display("wrap txn %0d pc=%h imm=%0d", got, dec_pc, dec_imm);
        got++;
      end
      if (acc) begin
        exp_q.push_back(if_pc);
        sent++;
      end
      tick();
    end
    if_valid = 1'b0; dec_ready = 1'b0;
    checks++; if (got !== 13 || sent !== 13) begin errors++;
      $display("FAIL wrap_total got received=%0d sent=%0d want 13/13", got, sent); end
    checks++; if (count !== 3'd0 || dec_valid !== 1'b0) begin errors++;
      $display("FAIL wrap_empty got count=%0d v=%0b want 0/0", count, dec_valid); end
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_decode();
    test_flush();
    test_illegal_freeze();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
